// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard scoreboard bundle: decoder/ID fields in,
// stall/issue decision and debug state out.
interface hazard_scoreboard_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [1:0]       id_num_reads;
    logic [2:0]       id_rs;
    logic [2:0]       id_rt;
    logic             id_reg_write;
    logic [2:0]       id_rd;
    logic             flush;
    logic             stall;
    logic             issue;
    logic [7:0]       busy_mask;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_num_reads, id_rs, id_rt,
        output id_reg_write, id_rd, flush,
        input  stall, issue, busy_mask, stall_cnt
    );

    modport slave (
        input  id_valid, id_num_reads, id_rs, id_rt,
        input  id_reg_write, id_rd, flush,
        output stall, issue, busy_mask, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard for a no-forwarding 5-stage pipeline.
// Pending destinations shift through DEPTH entries mirroring EX..WB.
module hazard_scoreboard #(
    parameter int DEPTH = 3,
    parameter int CNT_W = 16
) (
    input logic                clk,
    input logic                rst,
    hazard_scoreboard_if.slave sb
);
    logic [DEPTH-1:0]      r_v;
    logic [DEPTH-1:0][2:0] r_rd;
    logic [CNT_W-1:0]      r_cnt;

    logic [7:0] w_busy;
    logic       w_hit;
    logic       w_live;
    logic       w_stall;
    logic       w_issue;

    always_comb begin
        w_busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_v[i]) w_busy[r_rd[i]] = 1'b1;
        end
    end

    // Read count 3 behaves like 2.
    always_comb begin
        w_hit = 1'b0;
        unique case (sb.id_num_reads)
            2'd0:    w_hit = 1'b0;
            2'd1:    w_hit = w_busy[sb.id_rs];
            default: w_hit = w_busy[sb.id_rs] | w_busy[sb.id_rt];
        endcase
    end

    assign w_live  = sb.id_valid & ~sb.flush;
    assign w_stall = w_live & w_hit;
    assign w_issue = w_live & ~w_hit;

    // Shift every cycle; stalled/flushed slots enter as bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v   <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                r_v[i]  <= r_v[i-1];
                r_rd[i] <= r_rd[i-1];
            end
            r_v[0]  <= w_issue & sb.id_reg_write;
            r_rd[0] <= sb.id_rd;
            if (w_stall && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign sb.stall     = w_stall;
    assign sb.issue     = w_issue;
    assign sb.busy_mask = w_busy;
    assign sb.stall_cnt = r_cnt;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench for hazard_scoreboard; expected outputs are
// queued per cycle by the driver and checked by a separate monitor.
module tb_hazard_scoreboard;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.CNT_W(CNT_W)) bus ();

    hazard_scoreboard #(
        .DEPTH(3),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sb (bus)
    );

    typedef struct {
        string            tag;
        logic             stall;
        logic             issue;
        logic [7:0]       mask;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic step(
        input string      tag,
        input logic       r,
        input logic       v,
        input logic [1:0] nr,
        input logic [2:0] rs,
        input logic [2:0] rt,
        input logic       wr,
        input logic [2:0] rd,
        input logic       fl,
        input logic       es,
        input logic       ei,
        input logic [7:0] em,
        input int         ec
    );
        exp_t e;
        @(posedge clk);
        #1;
        rst              = r;
        bus.id_valid     = v;
        bus.id_num_reads = nr;
        bus.id_rs        = rs;
        bus.id_rt        = rt;
        bus.id_reg_write = wr;
        bus.id_rd        = rd;
        bus.flush        = fl;
        e.tag   = tag;
        e.stall = es;
        e.issue = ei;
        e.mask  = em;
        e.cnt   = ec[CNT_W-1:0];
        q.push_back(e);
    endtask

    // Monitor: outputs are combinational, so every cycle presents one.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_tests += 4;
            if (bus.stall !== e.stall) begin
                n_fail++;
                $display("FAIL %s stall got %0b want %0b",
                         e.tag, bus.stall, e.stall);
            end
            if (bus.issue !== e.issue) begin
                n_fail++;
                $display("FAIL %s issue got %0b want %0b",
                         e.tag, bus.issue, e.issue);
            end
            if (bus.busy_mask !== e.mask) begin
                n_fail++;
                $display("FAIL %s busy_mask got %h want %h",
                         e.tag, bus.busy_mask, e.mask);
            end
            if (bus.stall_cnt !== e.cnt) begin
                n_fail++;
                $display("FAIL %s stall_cnt got %0d want %0d",
                         e.tag, bus.stall_cnt, e.cnt);
            end
        end
    end

    initial begin
        int ec;
        int waited;
        bus.id_valid     = 1'b0;
        bus.id_num_reads = 2'd0;
        bus.id_rs        = 3'd0;
        bus.id_rt        = 3'd0;
        bus.id_reg_write = 1'b0;
        bus.id_rd        = 3'd0;
        bus.flush        = 1'b0;
        repeat (2) @(posedge clk);

        // tag      rst v nr rs rt wr rd fl | stall issue mask cnt
        step("reset",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0);

        // ADDI r3 then SUB r4,r3,r2: three stalls then issue
        step("addi",    0, 1, 1, 0, 0, 1, 3, 0, 0, 1, 8'h00, 0);
        step("sub_s1",  0, 1, 2, 3, 2, 1, 4, 0, 1, 0, 8'h08, 0);
        step("sub_s2",  0, 1, 2, 3, 2, 1, 4, 0, 1, 0, 8'h08, 1);
        step("sub_s3",  0, 1, 2, 3, 2, 1, 4, 0, 1, 0, 8'h08, 2);
        step("sub_iss", 0, 1, 2, 3, 2, 1, 4, 0, 0, 1, 8'h00, 3);
        step("mid_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h10, 3);
        step("post_rs", 0, 1, 1, 0, 0, 1, 5, 0, 0, 1, 8'h00, 0);

        // LBI with rs=r5 pending: no compare when reads=0
        step("lbi",     0, 1, 0, 5, 0, 1, 1, 0, 0, 1, 8'h20, 0);
        step("rd1_s1",  0, 1, 1, 5, 0, 0, 0, 0, 1, 0, 8'h22, 0);
        step("rd1_s2",  0, 1, 1, 5, 0, 0, 0, 0, 1, 0, 8'h22, 1);
        step("rd1_iss", 0, 1, 1, 5, 0, 0, 0, 0, 0, 1, 8'h02, 2);

        // r6 reaches entry 2, ST reads it via rt only
        step("w_r6",    0, 1, 0, 0, 0, 1, 6, 0, 0, 1, 8'h00, 2);
        step("idle1",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h40, 2);
        step("idle2",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h40, 2);
        step("st_s",    0, 1, 2, 1, 6, 0, 0, 0, 1, 0, 8'h40, 2);
        step("st_iss",  0, 1, 2, 1, 6, 0, 0, 0, 0, 1, 8'h00, 3);

        // flush beats hit; flushed writer must not enter entry 0
        step("w_r2",    0, 1, 0, 0, 0, 1, 2, 0, 0, 1, 8'h00, 3);
        step("fl_hit",  0, 1, 1, 2, 0, 1, 7, 1, 0, 0, 8'h04, 3);
        step("fl_nohz", 0, 1, 0, 0, 0, 1, 7, 1, 0, 0, 8'h04, 3);
        step("fl_chk1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h04, 3);
        step("fl_chk2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 3);

        // reads=3 compares rt like reads=2
        step("w_r1",    0, 1, 0, 0, 0, 1, 1, 0, 0, 1, 8'h00, 3);
        step("r3_s1",   0, 1, 3, 0, 1, 0, 0, 0, 1, 0, 8'h02, 3);
        step("r3_s2",   0, 1, 3, 0, 1, 0, 0, 0, 1, 0, 8'h02, 4);
        step("r3_s3",   0, 1, 3, 0, 1, 0, 0, 0, 1, 0, 8'h02, 5);
        step("r3_iss",  0, 1, 3, 0, 1, 0, 0, 0, 0, 1, 8'h00, 6);

        // chained r3 writers drive the 4-bit counter into saturation
        step("sat_w",   0, 1, 0, 0, 0, 1, 3, 0, 0, 1, 8'h00, 6);
        ec = 6;
        for (int it = 0; it < 7; it++) begin
            for (int j = 0; j < 3; j++) begin
                step("sat_s", 0, 1, 1, 3, 0, 1, 3, 0, 1, 0, 8'h08, ec);
                ec = (ec < 15) ? ec + 1 : 15;
            end
            step("sat_iss", 0, 1, 1, 3, 0, 1, 3, 0, 0, 1, 8'h00, ec);
        end
        step("sat_hold", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h08, 15);
        step("sat_rst",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0);

        waited = 0;
        while (q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending got %0d want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
